// File: rtl/env_sweep_scheduler.sv
// Owns the single environment write port: grants it to initializer writes during
// setup, and during the game phase raster-sweeps every grid cell once per game tick.
module env_sweep_scheduler #(
    parameter int X_bits    = 8,
    parameter int Y_bits    = 7,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119,
    parameter int CACHE_LAT = 2
) (
    input  logic              clk,
    input  logic              RESET_SIM,
    input  logic              run,
    input  logic              pause,
    input  logic              game_tick,
    input  logic              setup_req,
    input  logic [X_bits-1:0] setup_x,
    input  logic [Y_bits-1:0] setup_y,
    output logic              setup_gnt,
    output logic [X_bits-1:0] loc_x,
    output logic [Y_bits-1:0] loc_y,
    output logic              write_flag,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              tick_overrun,
    output logic [15:0]       frame_count
);

    localparam int CW = $clog2(CACHE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        WRITE,
        ADVANCE,
        DONE
    } state_t;

    state_t            state_q;
    logic [X_bits-1:0] loc_x_q;
    logic [Y_bits-1:0] loc_y_q;
    logic [CW-1:0]     wait_cnt_q;
    logic              write_flag_q;
    logic              setup_gnt_q;
    logic              sweep_busy_q;
    logic              sweep_done_q;
    logic              tick_overrun_q;
    logic [15:0]       frame_count_q;

    logic at_last_col;
    logic at_last_cell;

    assign at_last_col  = (loc_x_q == X_bits'(X_MAX));
    assign at_last_cell = at_last_col && (loc_y_q == Y_bits'(Y_MAX));

    // Strobes default low every cycle so write_flag, setup_gnt and sweep_done
    // are single-cycle pulses that only the state entered can raise.
    always_ff @(posedge clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state_q        <= IDLE;
            loc_x_q        <= '0;
            loc_y_q        <= '0;
            wait_cnt_q     <= '0;
            write_flag_q   <= 1'b0;
            setup_gnt_q    <= 1'b0;
            sweep_busy_q   <= 1'b0;
            sweep_done_q   <= 1'b0;
            tick_overrun_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            write_flag_q <= 1'b0;
            setup_gnt_q  <= 1'b0;
            sweep_done_q <= 1'b0;

            if (run && game_tick && (state_q != IDLE)) begin
                tick_overrun_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (!run && setup_req) begin
                        state_q      <= SETUP;
                        loc_x_q      <= setup_x;
                        loc_y_q      <= setup_y;
                        write_flag_q <= 1'b1;
                        setup_gnt_q  <= 1'b1;
                    end else if (run && !pause && game_tick) begin
                        state_q      <= WAIT;
                        loc_x_q      <= '0;
                        loc_y_q      <= '0;
                        wait_cnt_q   <= CW'(CACHE_LAT);
                        sweep_busy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= IDLE;
                end
                WAIT: begin
                    // Address has been stable for CACHE_LAT cycles once the count hits 1.
                    if (wait_cnt_q == CW'(1)) begin
                        state_q      <= WRITE;
                        write_flag_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                WRITE: begin
                    state_q <= ADVANCE;
                end
                ADVANCE: begin
                    if (!run) begin
                        state_q      <= IDLE;
                        loc_x_q      <= '0;
                        loc_y_q      <= '0;
                        sweep_busy_q <= 1'b0;
                    end else if (!pause) begin
                        if (at_last_cell) begin
                            state_q       <= DONE;
                            sweep_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                        end else begin
                            state_q    <= WAIT;
                            wait_cnt_q <= CW'(CACHE_LAT);
                            if (at_last_col) begin
                                loc_x_q <= '0;
                                loc_y_q <= loc_y_q + Y_bits'(1);
                            end else begin
                                loc_x_q <= loc_x_q + X_bits'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    sweep_busy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign setup_gnt    = setup_gnt_q;
    assign loc_x        = loc_x_q;
    assign loc_y        = loc_y_q;
    assign write_flag   = write_flag_q;
    assign sweep_busy   = sweep_busy_q;
    assign sweep_done   = sweep_done_q;
    assign tick_overrun = tick_overrun_q;
    assign frame_count  = frame_count_q;

endmodule

// File: doc/env_sweep_scheduler.md
Name: env_sweep_scheduler

Overview:
- Sequences the single environment write port: during the game phase it raster-sweeps every grid cell once per game tick, waits for env_cache read data to settle, then pulses the write strobe.
- During setup it grants the port to initializer writes (sugar-patch placement).
- Sits between the initializer/game clock sources and the environment + env_cache pair; drives their write address and write_flag.

Parameters:
- X_bits, 8, grid column address width
- Y_bits, 7, grid row address width
- X_MAX, 159, last column index
- Y_MAX, 119, last row index
- CACHE_LAT, 2, cycles from address change to valid env_cache/nextSugar/nextSignal data (must be >=1)

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- RESET_SIM  input  1  asynchronous, active-high reset
- run  input  1  1 = game phase (~SETUP_MODE), 0 = setup phase
- pause  input  1  level; freezes sweep advance
- game_tick  input  1  one-cycle pulse per game step (edge-detected game clock)
- setup_req  input  1  initializer write request (level)
- setup_x  input  X_bits  initializer write column
- setup_y  input  Y_bits  initializer write row
- setup_gnt  output  1  one-cycle pulse; setup write performed this cycle
- loc_x  output  X_bits  write/lookup column to environment and env_cache
- loc_y  output  Y_bits  write/lookup row
- write_flag  output  1  environment write strobe, one cycle per write
- sweep_busy  output  1  high while a sweep is in progress
- sweep_done  output  1  one-cycle pulse at sweep completion
- tick_overrun  output  1  sticky; a game_tick arrived while busy
- frame_count  output  16  completed sweeps, wraps at 65535 -> 0

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; loc=0,0; write_flag, setup_gnt, sweep_busy, sweep_done, tick_overrun = 0; frame_count=0.
- States: IDLE, SETUP, WAIT, WRITE, ADVANCE, DONE.
- IDLE:
  - run=0 & setup_req=1 -> SETUP; loc<=setup_x/y, write_flag<=1, setup_gnt<=1.
  - run=1 & pause=0 & game_tick=1 -> WAIT; loc<=0,0; wait counter<=CACHE_LAT; sweep_busy<=1.
  - game_tick with pause=1 or run=0: ignored, not queued.
- SETUP: exactly one cycle, -> IDLE. write_flag and setup_gnt high only this cycle. Maximum setup write rate is one per 2 cycles. setup_req while run=1 is ignored, setup_gnt stays 0.
- WAIT: loc held stable, counter decrements. When it reaches 1 -> WRITE. Dwell is exactly CACHE_LAT cycles.
- WRITE: write_flag=1 for exactly one cycle with loc unchanged, -> ADVANCE.
- ADVANCE:
  - run=0: abort; -> IDLE, loc<=0,0, sweep_busy<=0, no sweep_done, frame_count unchanged.
  - else pause=1: stay in ADVANCE, loc frozen, no writes.
  - else if loc=(X_MAX,Y_MAX): -> DONE.
  - else if loc_x=X_MAX: loc_x<=0, loc_y<=loc_y+1, -> WAIT.
  - else: loc_x<=loc_x+1, -> WAIT.
  - Every transition to WAIT reloads the counter with CACHE_LAT.
- Abort precedence in ADVANCE: run deassert overrides pause.
- DONE: sweep_done=1 for one cycle, frame_count+1, sweep_busy<=0, -> IDLE.
- Per-cell cost is CACHE_LAT+2 cycles; each cell is written exactly once per sweep, in raster order (x fastest).
- tick_overrun: set when game_tick=1 in any state other than IDLE while run=1. Cleared only by reset. That tick is dropped.
- write_flag is never high outside the SETUP and WRITE states, and never in two consecutive cycles.
- run deasserted during WAIT or WRITE: the current cell completes its write, then the sweep aborts at ADVANCE.

Test Plan:
- Reset mid-sweep (X_MAX=3, Y_MAX=2, CACHE_LAT=2): assert RESET_SIM during WAIT -> same-edge outputs 0, loc=0,0, frame_count=0, state IDLE.
- Full sweep, same params, one game_tick -> 12 write_flag pulses at loc (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), each 4 cycles apart. sweep_done high exactly 48 edges after the tick-sampling edge; frame_count=1.
- Setup writes, run=0, setup_req held 6 cycles with coords (5,7) -> 3 setup_gnt pulses each with write_flag and loc=(5,7). With run=1, same stimulus -> no grants, no writes.
- Pause: assert pause while in ADVANCE at loc (1,0) for 10 cycles -> no write_flag, loc stays (1,0). Release -> next write at (2,0) after 3 cycles; total sweep length extended by 10.
- Overrun and abort: second game_tick mid-sweep -> tick_overrun=1, still 12 writes. Then a new sweep with run dropped in WAIT at (2,1) -> that cell is written, then IDLE, sweep_busy=0, no sweep_done, frame_count unchanged.
- Wrap: preload 65535 sweeps (or force frame_count) and complete one more sweep -> frame_count=0, sweep_done pulses normally.
